// File: rtl/bist_pkg.sv
// Shared definitions for the ALU logic-BIST engine: FSM state encoding and
// default LFSR/MISR polynomials and seed.
package bist_pkg;

  localparam int unsigned ST_W = 3;

  localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [ST_W-1:0] ST_SEED    = 3'd1;
  localparam logic [ST_W-1:0] ST_RUN     = 3'd2;
  localparam logic [ST_W-1:0] ST_DRAIN   = 3'd3;
  localparam logic [ST_W-1:0] ST_COMPARE = 3'd4;
  localparam logic [ST_W-1:0] ST_DONE    = 3'd5;

  localparam logic [31:0] DEF_LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] DEF_MISR_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] DEF_SEED      = 32'hACE1_0001;

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register: shift-left Galois compaction of din
// whenever en is high; clr has priority and zeroes the signature.
module bist_misr
  import bist_pkg::*;
#(
  parameter int unsigned      RES_W     = 32,
  parameter logic [RES_W-1:0] MISR_POLY = RES_W'(DEF_MISR_POLY)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [RES_W-1:0] din,
  output logic [RES_W-1:0] sig
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= {sig[RES_W-2:0], 1'b0} ^ (sig[RES_W-1] ? MISR_POLY : '0) ^ din;
    end
  end

endmodule

// File: rtl/alu_bist_engine.sv
// ALU logic-BIST engine: LFSR operand stimulus, latency-aligned MISR compaction
// and golden-signature compare. Optional back-to-back runs with BIST_CONTINUOUS_EN.
module alu_bist_engine
  import bist_pkg::*;
#(
  parameter int unsigned      DATA_W    = 12,
  parameter int unsigned      OP_W      = 3,
  parameter int unsigned      RES_W     = 32,
  parameter logic [31:0]      LFSR_POLY = DEF_LFSR_POLY,
  parameter logic [RES_W-1:0] MISR_POLY = RES_W'(DEF_MISR_POLY),
  parameter logic [31:0]      SEED      = DEF_SEED,
  parameter int unsigned      NUM_PAT   = 256,
  parameter int unsigned      RESP_LAT  = 1,
  parameter int unsigned      CNT_W     = $clog2(NUM_PAT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [RES_W-1:0]  golden_sig,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [RES_W-1:0]  alu_res,
  output logic              test_active,
  output logic              done,
  output logic              pass,
  output logic [RES_W-1:0]  signature,
  output logic [CNT_W-1:0]  pat_cnt
`ifdef BIST_CONTINUOUS_EN
  ,
  input  logic              loop,
  output logic [7:0]        run_cnt
`endif
);

  localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam int unsigned PW       = (RESP_LAT == 0) ? 1 : RESP_LAT;

  logic [ST_W-1:0] state, state_d;
  logic [31:0]     lfsr, lfsr_raw, lfsr_step, lfsr_d;
  logic [2:0]      drain_cnt;
  logic [PW-1:0]   vpipe;
  logic            run_d, absorb, match;
`ifdef BIST_CONTINUOUS_EN
  logic            fail_seen;
`endif

  // Galois step with lockup escape
  always_comb begin
    lfsr_raw  = {lfsr[30:0], 1'b0} ^ (lfsr[31] ? LFSR_POLY : 32'd0);
    lfsr_step = (lfsr_raw == 32'd0) ? 32'd1 : lfsr_raw;
  end

  always_comb begin
    lfsr_d = lfsr;
    if (state == ST_SEED) begin
      lfsr_d = SEED_EFF;
    end else if (state == ST_RUN) begin
      lfsr_d = lfsr_step;
    end
  end

  // Next-state logic; abort overrides every other transition
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:    if (start) state_d = ST_SEED;
      ST_SEED:    state_d = ST_RUN;
      ST_RUN:     if (pat_cnt == CNT_W'(NUM_PAT - 1)) state_d = ST_DRAIN;
      ST_DRAIN:   if (drain_cnt == 3'(RESP_LAT)) state_d = ST_COMPARE;
      ST_COMPARE: state_d = ST_DONE;
      ST_DONE: begin
`ifdef BIST_CONTINUOUS_EN
        if (loop) state_d = ST_SEED;
        else if (!start) state_d = ST_IDLE;
`else
        if (!start) state_d = ST_IDLE;
`endif
      end
      default:    state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  assign run_d  = (state_d == ST_RUN);
  assign match  = (signature == golden_sig);
  // The tag emerging from the valid pipe marks the cycle the matching result is on alu_res
  assign absorb = (RESP_LAT == 0) ? (state == ST_RUN) : vpipe[PW-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      lfsr        <= SEED_EFF;
      pat_cnt     <= '0;
      drain_cnt   <= '0;
      vpipe       <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
      test_active <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
    end else begin
      state  <= state_d;
      lfsr   <= lfsr_d;
      // Operands mirror the LFSR exactly while in RUN, zero elsewhere
      alu_a  <= run_d ? lfsr_d[DATA_W-1:0] : '0;
      alu_b  <= run_d ? lfsr_d[2*DATA_W-1:DATA_W] : '0;
      alu_op <= run_d ? lfsr_d[31:32-OP_W] : '0;
      test_active <= (state_d == ST_SEED) || (state_d == ST_RUN) ||
                     (state_d == ST_DRAIN) || (state_d == ST_COMPARE);
      done   <= (state_d == ST_DONE);
      vpipe  <= abort ? '0 : PW'({vpipe, state == ST_RUN});

      if (abort || state == ST_SEED) begin
        pat_cnt <= '0;
      end else if (state == ST_RUN) begin
        pat_cnt <= pat_cnt + CNT_W'(1);
      end

      // DRAIN lasts RESP_LAT+1 cycles so the last absorption lands before COMPARE
      drain_cnt <= (state == ST_DRAIN) ? drain_cnt + 3'd1 : 3'd0;

      if (state_d == ST_IDLE) begin
        pass <= 1'b0;
      end else if (state == ST_COMPARE) begin
`ifdef BIST_CONTINUOUS_EN
        pass <= match && !fail_seen;
`else
        pass <= match;
`endif
      end
    end
  end

`ifdef BIST_CONTINUOUS_EN
  // A failing run keeps pass low for every later run until IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fail_seen <= 1'b0;
      run_cnt   <= '0;
    end else if (state_d == ST_IDLE) begin
      fail_seen <= 1'b0;
      run_cnt   <= '0;
    end else if (state == ST_COMPARE && state_d == ST_DONE) begin
      fail_seen <= fail_seen || !match;
      run_cnt   <= run_cnt + 8'd1;
    end
  end
`endif

  bist_misr #(
    .RES_W    (RES_W),
    .MISR_POLY(MISR_POLY)
  ) u_misr (
    .clk(clk),
    .rst(rst),
    .clr(state == ST_SEED),
    .en (absorb),
    .din(alu_res),
    .sig(signature)
  );

endmodule

// File: tb/tb_alu_bist_engine.sv
// Directed bench for alu_bist_engine: default instance with a registered
// reference ALU, plus an edge-parameter instance (SEED=0, NUM_PAT=1, RESP_LAT=0).
module tb_alu_bist_engine;

  logic        clk, rst, start, abort;
  logic [31:0] golden, alu_res, res_q, fault_mask;
  logic [11:0] alu_a, alu_b;
  logic [2:0]  alu_op;
  logic        test_active, done, pass;
  logic [31:0] signature;
  logic [8:0]  pat_cnt;

  logic        start2;
  logic [31:0] alu_res2, signature2;
  logic [11:0] alu_a2, alu_b2;
  logic [2:0]  alu_op2;
  logic        test_active2, done2, pass2;
  logic [0:0]  pat_cnt2;
`ifdef BIST_CONTINUOUS_EN
  logic        loop, loop2;
  logic [7:0]  run_cnt, run_cnt2;
`endif

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] alu_fn(input logic [11:0] a, input logic [11:0] b,
                                         input logic [2:0] op);
    case (op)
      3'd0:    return {20'd0, a} + {20'd0, b};
      3'd1:    return {20'd0, a} - {20'd0, b};
      3'd2:    return {20'd0, a & b};
      3'd3:    return {20'd0, a | b};
      3'd4:    return {20'd0, a ^ b};
      3'd5:    return {20'd0, a} * {20'd0, b};
      3'd6:    return {8'd0, a, b};
      default: return ~{8'd0, a, b};
    endcase
  endfunction

  // Reference signature: walk the LFSR, run the ALU, compact with the MISR
  function automatic logic [31:0] model_sig(input logic [31:0] seed, input int n,
                                            input logic [31:0] mask);
    logic [31:0] l, s, r;
    l = (seed == 32'd0) ? 32'd1 : seed;
    s = 32'd0;
    for (int k = 0; k < n; k++) begin
      r = alu_fn(l[11:0], l[23:12], l[31:29]) ^ mask;
      s = {s[30:0], 1'b0} ^ (s[31] ? 32'h04C1_1DB7 : 32'd0) ^ r;
      l = {l[30:0], 1'b0} ^ (l[31] ? 32'h8020_0003 : 32'd0);
      if (l == 32'd0) l = 32'd1;
    end
    return s;
  endfunction

  always #5 clk = ~clk;
  always @(posedge clk) res_q <= alu_fn(alu_a, alu_b, alu_op);
  assign alu_res  = res_q ^ fault_mask;
  assign alu_res2 = alu_fn(alu_a2, alu_b2, alu_op2);

  alu_bist_engine dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .golden_sig(golden),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_res(alu_res),
    .test_active(test_active), .done(done), .pass(pass),
    .signature(signature), .pat_cnt(pat_cnt)
`ifdef BIST_CONTINUOUS_EN
    , .loop(loop), .run_cnt(run_cnt)
`endif
  );

  alu_bist_engine #(.SEED(32'h0), .NUM_PAT(1), .RESP_LAT(0)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(1'b0), .golden_sig(32'h1),
    .alu_a(alu_a2), .alu_b(alu_b2), .alu_op(alu_op2), .alu_res(alu_res2),
    .test_active(test_active2), .done(done2), .pass(pass2),
    .signature(signature2), .pat_cnt(pat_cnt2)
`ifdef BIST_CONTINUOUS_EN
    , .loop(loop2), .run_cnt(run_cnt2)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1; cyc++;
    end while (!done && cyc < 3000);
  endtask

  task automatic do_run(input logic [31:0] mask, output int cyc);
    fault_mask = mask;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    wait_done(cyc);
  endtask

  typedef struct { logic [31:0] mask; logic exp_pass; int exp_cyc; } run_vec_t;
  typedef struct { logic [11:0] a; logic [11:0] b; logic [2:0] op; } op_vec_t;

  run_vec_t    runs[3];
  op_vec_t     opv[5];
  logic [31:0] gold0, exp_sig;
  int          cyc, n;

  initial begin
    runs[0] = '{mask: 32'h0,         exp_pass: 1'b1, exp_cyc: 260};
    runs[1] = '{mask: 32'h0000_0100, exp_pass: 1'b0, exp_cyc: 260};
    runs[2] = '{mask: 32'h8000_0001, exp_pass: 1'b0, exp_cyc: 260};
    // LFSR from ACE10001: ACE10001, D9E20001, 33E40001, 67C80002, CF900004
    opv[0] = '{a: 12'h001, b: 12'hE10, op: 3'd5};
    opv[1] = '{a: 12'h001, b: 12'hE20, op: 3'd6};
    opv[2] = '{a: 12'h001, b: 12'hE40, op: 3'd1};
    opv[3] = '{a: 12'h002, b: 12'hC80, op: 3'd3};
    opv[4] = '{a: 12'h004, b: 12'h900, op: 3'd6};

    gold0 = model_sig(32'hACE1_0001, 256, 32'h0);
    clk = 1'b0; rst = 1'b0; start = 1'b1; abort = 1'b0; start2 = 1'b1;
    golden = gold0; fault_mask = 32'h0;
`ifdef BIST_CONTINUOUS_EN
    loop = 1'b0; loop2 = 1'b0;
`endif

    // Reset with start held high
    repeat (3) @(posedge clk);
    #1;
    check("rst_alu_a", 32'(alu_a), 32'h0);
    check("rst_alu_b", 32'(alu_b), 32'h0);
    check("rst_alu_op", 32'(alu_op), 32'h0);
    check("rst_test_active", 32'(test_active), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_pass", 32'(pass), 32'h0);
    check("rst_signature", signature, 32'h0);
    check("rst_pat_cnt", 32'(pat_cnt), 32'h0);
    @(negedge clk); start = 1'b0; start2 = 1'b0; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_after_rst", 32'(test_active), 32'h0);

    // Table of full runs with different fault masks
    for (int i = 0; i < 3; i++) begin
      exp_sig = model_sig(32'hACE1_0001, 256, runs[i].mask);
      do_run(runs[i].mask, cyc);
      check("run_done_cycle", 32'(cyc), 32'(runs[i].exp_cyc));
      check("run_pass", 32'(pass), 32'(runs[i].exp_pass));
      check("run_pat_cnt", 32'(pat_cnt), 32'd256);
      check("run_signature", signature, exp_sig);
      check("run_ops_zero_in_done", {8'd0, alu_a, alu_b}, 32'h0);
      check("run_active_in_done", 32'(test_active), 32'h0);
      @(negedge clk); start = 1'b0; fault_mask = 32'h0;
      @(posedge clk); #1;
      check("exit_done", 32'(done), 32'h0);
      check("exit_pass", 32'(pass), 32'h0);
    end

    // Operand sequence, start dropped mid-run, abort at pat_cnt=100
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("op_a", 32'(alu_a), 32'(opv[k].a));
      check("op_b", 32'(alu_b), 32'(opv[k].b));
      check("op_code", 32'(alu_op), 32'(opv[k].op));
    end
    @(negedge clk); start = 1'b0;
    n = 0;
    while (pat_cnt != 9'd100 && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    check("abort_pat_cnt_reached", 32'(pat_cnt), 32'd100);
    check("start_drop_ignored", 32'(test_active), 32'h1);
    @(negedge clk); abort = 1'b1;
    @(posedge clk); #1;
    check("abort_active", 32'(test_active), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    check("abort_pass", 32'(pass), 32'h0);
    check("abort_pat_cnt", 32'(pat_cnt), 32'h0);
    check("abort_ops", {8'd0, alu_a, alu_b}, 32'h0);
    @(negedge clk); abort = 1'b0;
    do_run(32'h0, cyc);
    check("rerun_cycle", 32'(cyc), 32'd260);
    check("rerun_pass", 32'(pass), 32'h1);
    check("rerun_signature", signature, gold0);
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;

    // Edge parameters: SEED=0 -> 1, one pattern, zero latency
    @(negedge clk); start2 = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    check("edge_first_a", 32'(alu_a2), 32'h1);
    check("edge_first_b_op", {17'd0, alu_b2, alu_op2}, 32'h0);
    cyc = 1;
    while (!done2 && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    check("edge_done_cycle", 32'(cyc), 32'd4);
    check("edge_signature", signature2, 32'h1);
    check("edge_pass", 32'(pass2), 32'h1);
    check("edge_pat_cnt", 32'(pat_cnt2), 32'h1);
    repeat (2) @(posedge clk);
    #1;
    check("edge_sig_frozen", signature2, 32'h1);
    check("edge_done_held", 32'(done2), 32'h1);
    @(negedge clk); start2 = 1'b0;

`ifdef BIST_CONTINUOUS_EN
    // Continuous runs, fault only in run 2
    @(negedge clk); loop = 1'b1; start = 1'b1; fault_mask = 32'h0;
    @(posedge clk);
    wait_done(cyc);
    check("loop1_cycle", 32'(cyc), 32'd260);
    check("loop1_run_cnt", 32'(run_cnt), 32'd1);
    check("loop1_pass", 32'(pass), 32'h1);
    fault_mask = 32'h0000_0100;
    @(posedge clk); #1;
    check("loop1_done_pulse", 32'(done), 32'h0);
    wait_done(cyc);
    check("loop2_cycle", 32'(cyc), 32'd260);
    check("loop2_run_cnt", 32'(run_cnt), 32'd2);
    check("loop2_pass", 32'(pass), 32'h0);
    fault_mask = 32'h0;
    @(posedge clk); #1;
    check("loop2_done_pulse", 32'(done), 32'h0);
    wait_done(cyc);
    check("loop3_cycle", 32'(cyc), 32'd260);
    check("loop3_run_cnt", 32'(run_cnt), 32'd3);
    check("loop3_pass_sticky", 32'(pass), 32'h0);
    @(negedge clk); loop = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    check("loop_exit_run_cnt", 32'(run_cnt), 32'h0);
    check("loop_exit_done", 32'(done), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
